ysyx_22050612_wbu: RTL and testbench

Writeback unit: the write-side driver of the integer register file. It arbitrates completed results from the execute unit (EXU) and the load/store unit (LSU) onto the register file's single write port (`wen`/`waddr`/`wdata`). It also keeps a per-register pending scoreboard that the decode stage queries for RAW hazards. It sits between EXU/LSU and the register file, one registered stage before the write edge.

---
 rtl/ysyx_22050612_wbu_pkg.sv | 12 +
 rtl/ysyx_22050612_wbu_if.sv | 42 ++++
 rtl/ysyx_22050612_scoreboard.sv | 44 ++++
 rtl/ysyx_22050612_wbu.sv | 84 ++++++++
 tb/tb_ysyx_22050612_wbu.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050612_wbu_pkg.sv
// Shared types and default widths for the writeback unit and its scoreboard.
package ysyx_22050612_wbu_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    typedef enum logic {
        GNT_EXU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

endpackage

// File: rtl/ysyx_22050612_wbu_if.sv
// Result, issue and register-file-write bundle between the pipeline and the writeback unit.
interface ysyx_22050612_wbu_if
    import ysyx_22050612_wbu_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_AW,
    parameter int DATA_WIDTH = XLEN
);
    logic                  iss_valid;
    logic                  iss_ready;
    logic [ADDR_WIDTH-1:0] iss_rd;
    logic                  exu_valid;
    logic                  exu_ready;
    logic [ADDR_WIDTH-1:0] exu_rd;
    logic [DATA_WIDTH-1:0] exu_data;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic                  busy1;
    logic                  busy2;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [31:0]           wb_count;

    modport slave (
        input  iss_valid, iss_rd, exu_valid, exu_rd, exu_data,
               lsu_valid, lsu_rd, lsu_data, rs1, rs2,
        output iss_ready, exu_ready, lsu_ready, busy1, busy2,
               wen, waddr, wdata, wb_count
    );

    modport master (
        output iss_valid, iss_rd, exu_valid, exu_rd, exu_data,
               lsu_valid, lsu_rd, lsu_data, rs1, rs2,
        input  iss_ready, exu_ready, lsu_ready, busy1, busy2,
               wen, waddr, wdata, wb_count
    );

endinterface

// File: rtl/ysyx_22050612_scoreboard.sv
// Per-register pending-write bits with set-wins priority; x0 is never pending.
module ysyx_22050612_scoreboard
    import ysyx_22050612_wbu_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_AW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_set_en,
    input  logic [ADDR_WIDTH-1:0] i_set_idx,
    input  logic                  i_clr_en,
    input  logic [ADDR_WIDTH-1:0] i_clr_idx,
    input  logic [ADDR_WIDTH-1:0] i_iss_rd,
    input  logic [ADDR_WIDTH-1:0] i_rs1,
    input  logic [ADDR_WIDTH-1:0] i_rs2,
    output logic                  o_iss_busy,
    output logic                  o_busy1,
    output logic                  o_busy2
);
    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0] r_pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending[0] <= 1'b0;
            // Set is checked first so a same-cycle issue re-arms a register being retired.
            for (int i = 1; i < NREG; i++) begin
                if (i_set_en && i_set_idx == ADDR_WIDTH'(i)) begin
                    r_pending[i] <= 1'b1;
                end else if (i_clr_en && i_clr_idx == ADDR_WIDTH'(i)) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    assign o_iss_busy = r_pending[i_iss_rd];
    assign o_busy1    = r_pending[i_rs1];
    assign o_busy2    = r_pending[i_rs2];

endmodule

// File: rtl/ysyx_22050612_wbu.sv
// Writeback unit: round-robin EXU/LSU arbitration onto the single register-file write port.
module ysyx_22050612_wbu
    import ysyx_22050612_wbu_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_AW,
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                clk,
    input  logic                rst_n,
    ysyx_22050612_wbu_if.slave  bus
);
    grant_e                r_last_grant;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [31:0]           r_wb_count;

    logic                  w_grant_lsu;
    logic                  w_exu_hs;
    logic                  w_lsu_hs;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_rd;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_iss_busy;
    logic                  w_iss_ready;
    logic                  w_iss_set;

    // LSU wins when alone, or in a conflict when EXU had the previous grant.
    assign w_grant_lsu   = bus.lsu_valid && (!bus.exu_valid || r_last_grant == GNT_EXU);
    assign bus.exu_ready = rst_n && bus.exu_valid && !w_grant_lsu;
    assign bus.lsu_ready = rst_n && w_grant_lsu;

    assign w_exu_hs = bus.exu_valid && bus.exu_ready;
    assign w_lsu_hs = bus.lsu_valid && bus.lsu_ready;
    assign w_accept = w_exu_hs || w_lsu_hs;
    assign w_rd     = w_lsu_hs ? bus.lsu_rd   : bus.exu_rd;
    assign w_data   = w_lsu_hs ? bus.lsu_data : bus.exu_data;

    assign w_iss_ready   = rst_n && !w_iss_busy;
    assign bus.iss_ready = w_iss_ready;
    assign w_iss_set     = bus.iss_valid && w_iss_ready && (bus.iss_rd != '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wen        <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_wb_count   <= '0;
            r_last_grant <= GNT_EXU;
        end else begin
            r_wen <= w_accept && (w_rd != '0);
            if (w_accept) begin
                r_waddr      <= w_rd;
                r_wdata      <= w_data;
                r_wb_count   <= r_wb_count + 32'd1;
                r_last_grant <= w_lsu_hs ? GNT_LSU : GNT_EXU;
            end
        end
    end

    assign bus.wen      = r_wen;
    assign bus.waddr    = r_waddr;
    assign bus.wdata    = r_wdata;
    assign bus.wb_count = r_wb_count;

    ysyx_22050612_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (w_iss_set),
        .i_set_idx  (bus.iss_rd),
        .i_clr_en   (r_wen),
        .i_clr_idx  (r_waddr),
        .i_iss_rd   (bus.iss_rd),
        .i_rs1      (bus.rs1),
        .i_rs2      (bus.rs2),
        .o_iss_busy (w_iss_busy),
        .o_busy1    (bus.busy1),
        .o_busy2    (bus.busy2)
    );

endmodule

// File: tb/tb_ysyx_22050612_wbu.sv
// Self-checking bench for the writeback unit: directed scenarios then randomized traffic vs a behavioural model.
module tb_ysyx_22050612_wbu;
    import ysyx_22050612_wbu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_22050612_wbu_if bus ();

    ysyx_22050612_wbu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: set of pending registers, who won last, and the expected write-port contents.
    bit          m_pend [32];
    bit          m_last_lsu;
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [63:0] m_wdata;
    int unsigned m_cnt;
    bit          m_port_zero;
    bit          m_exu_acc;
    bit          m_lsu_acc;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_last_lsu  = 1'b0;
        m_wen       = 1'b0;
        m_waddr     = '0;
        m_wdata     = '0;
        m_cnt       = 0;
        m_port_zero = 1'b1;
    endtask

    // One clock: compare everything observable against the model, then advance the model past the edge.
    task automatic tick();
        bit         e_exu, e_lsu, e_iss, take_lsu;
        logic [4:0] rd;
        #1;
        e_exu = 1'b0; e_lsu = 1'b0; e_iss = 1'b0;
        if (rst_n) begin
            if (bus.exu_valid && bus.lsu_valid) take_lsu = !m_last_lsu;
            else                                take_lsu = bus.lsu_valid;
            e_lsu = take_lsu;
            e_exu = bus.exu_valid && !take_lsu;
            e_iss = (bus.iss_rd == 5'd0) || !m_pend[bus.iss_rd];
        end
        check("exu_ready", 64'(bus.exu_ready), 64'(e_exu));
        check("lsu_ready", 64'(bus.lsu_ready), 64'(e_lsu));
        check("iss_ready", 64'(bus.iss_ready), 64'(e_iss));
        check("busy1",     64'(bus.busy1),     64'(m_pend[bus.rs1]));
        check("busy2",     64'(bus.busy2),     64'(m_pend[bus.rs2]));
        check("wen",       64'(bus.wen),       64'(m_wen));
        check("wb_count",  64'(bus.wb_count),  64'(m_cnt));
        if (m_wen || m_port_zero) begin
            check("waddr", 64'(bus.waddr), 64'(m_waddr));
            check("wdata", bus.wdata,      m_wdata);
        end
        m_exu_acc = e_exu;
        m_lsu_acc = e_lsu;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_wen) m_pend[m_waddr] = 1'b0;
            if (bus.iss_valid && e_iss && bus.iss_rd != 5'd0) m_pend[bus.iss_rd] = 1'b1;
            if (e_exu || e_lsu) begin
                rd          = e_lsu ? bus.lsu_rd : bus.exu_rd;
                m_wen       = (rd != 5'd0);
                m_waddr     = rd;
                m_wdata     = e_lsu ? bus.lsu_data : bus.exu_data;
                m_cnt       = m_cnt + 1;
                m_last_lsu  = e_lsu;
                m_port_zero = 1'b0;
            end else begin
                m_wen = 1'b0;
            end
        end
        #1;
    endtask

    task automatic drive_exu(bit v, logic [4:0] rd, logic [63:0] d);
        bus.exu_valid = v; bus.exu_rd = rd; bus.exu_data = d;
    endtask

    task automatic drive_lsu(bit v, logic [4:0] rd, logic [63:0] d);
        bus.lsu_valid = v; bus.lsu_rd = rd; bus.lsu_data = d;
    endtask

    task automatic drive_iss(bit v, logic [4:0] rd);
        bus.iss_valid = v; bus.iss_rd = rd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        drive_exu(1'b0, '0, '0);
        drive_lsu(1'b0, '0, '0);
        drive_iss(1'b0, '0);
        bus.rs1 = '0;
        bus.rs2 = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Results offered during reset must not be taken.
        drive_exu(1'b1, 5'd5, 64'h1234);
        tick();
        tick();
        check("reset_wb_count", 64'(bus.wb_count), 64'd0);
        rst_n = 1'b1;

        // EXU alone.
        tick();
        drive_exu(1'b0, '0, '0);
        check("exu_only_wen",   64'(bus.wen),      64'd1);
        check("exu_only_waddr", 64'(bus.waddr),    64'd5);
        check("exu_only_wdata", bus.wdata,         64'h1234);
        check("exu_only_count", 64'(bus.wb_count), 64'd1);
        tick();
        check("exu_only_wen_pulse", 64'(bus.wen), 64'd0);

        // Continuous dual-valid traffic from reset alternates LSU, EXU, ...
        do_reset();
        drive_exu(1'b1, 5'd1, 64'hA1);
        drive_lsu(1'b1, 5'd2, 64'hB2);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_waddr", 64'(bus.waddr), (k % 2 == 0) ? 64'd2 : 64'd1);
        end
        drive_exu(1'b0, '0, '0);
        drive_lsu(1'b0, '0, '0);

        // x0 write from LSU: counted, not written, and LSU now holds the last grant.
        do_reset();
        drive_lsu(1'b1, 5'd0, 64'hFFFF);
        tick();
        check("x0_wen",   64'(bus.wen),      64'd0);
        check("x0_count", 64'(bus.wb_count), 64'd1);
        drive_exu(1'b1, 5'd4, 64'h44);
        drive_lsu(1'b1, 5'd6, 64'h66);
        tick();
        check("x0_then_exu_wins", 64'(bus.waddr), 64'd4);
        drive_exu(1'b0, '0, '0);
        tick();
        drive_lsu(1'b0, '0, '0);
        tick();

        // Scoreboard: issue, WAW stall, retirement latency.
        bus.rs1 = 5'd7;
        drive_iss(1'b1, 5'd7);
        tick();
        check("sb_busy_after_issue", 64'(bus.busy1), 64'd1);
        tick();
        drive_iss(1'b0, '0);
        drive_exu(1'b1, 5'd7, 64'h77);
        tick();
        drive_exu(1'b0, '0, '0);
        check("sb_busy_at_n1", 64'(bus.busy1), 64'd1);
        tick();
        check("sb_busy_at_n2", 64'(bus.busy1), 64'd0);
        drive_iss(1'b1, 5'd7);
        #1;
        check("sb_iss_ready_at_n2", 64'(bus.iss_ready), 64'd1);
        drive_iss(1'b0, '0);

        // Same-cycle set and clear on x9: set wins.
        bus.rs2 = 5'd9;
        drive_exu(1'b1, 5'd9, 64'h99);
        tick();
        drive_exu(1'b0, '0, '0);
        check("setclr_wen",   64'(bus.wen),   64'd1);
        check("setclr_waddr", 64'(bus.waddr), 64'd9);
        drive_iss(1'b1, 5'd9);
        tick();
        drive_iss(1'b0, '0);
        tick();
        check("setclr_pending", 64'(bus.busy2), 64'd1);

        // Reset the cycle after a handshake.
        drive_lsu(1'b1, 5'd3, 64'h33);
        tick();
        drive_lsu(1'b0, '0, '0);
        rst_n = 1'b0;
        tick();
        check("midrst_wen",   64'(bus.wen),      64'd0);
        check("midrst_count", 64'(bus.wb_count), 64'd0);
        check("midrst_busy2", 64'(bus.busy2),    64'd0);
        rst_n = 1'b1;

        // Randomized traffic: sources hold offers until accepted; occasional resets.
        for (int c = 0; c < 600; c++) begin
            if (!bus.exu_valid || m_exu_acc)
                drive_exu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
            if (!bus.lsu_valid || m_lsu_acc)
                drive_lsu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
            drive_iss(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
            bus.rs1 = 5'($urandom_range(0, 7));
            bus.rs2 = 5'($urandom_range(0, 7));
            rst_n   = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
